// File: rtl/pipeline_tracker.sv
// Sequence-ID tracker for a 5-stage pipeline.
// Carries a wrapping ID/valid pair through the IF/ID/EX/MEM/WB stages, with stall bubbles and flush squashes.
module pipeline_tracker #(
  parameter int DEPTH = 72,
  parameter int ID_W  = $clog2(DEPTH),
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush_if,
  input  logic             flush_id,
  input  logic             halt,
  output logic [ID_W-1:0]  fetch_id,
  output logic             fetch_valid,
  output logic [ID_W-1:0]  decode_id,
  output logic             decode_valid,
  output logic [ID_W-1:0]  execute_id,
  output logic             execute_valid,
  output logic [ID_W-1:0]  memory_id,
  output logic             memory_valid,
  output logic [ID_W-1:0]  wb_id,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] squash_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             drained
);

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(DEPTH - 1)) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W - 1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  logic            halted;
  logic            halted_d;
  logic [ID_W-1:0] fetch_id_d;
  logic            fetch_valid_d;
  logic [ID_W-1:0] decode_id_d;
  logic            decode_valid_d;
  logic            execute_valid_d;
  logic [1:0]      squash_inc;
  logic            any_valid;

  always_comb begin
    halted_d        = halted | halt;
    fetch_id_d      = fetch_id;
    fetch_valid_d   = fetch_valid;
    decode_id_d     = decode_id;
    decode_valid_d  = decode_valid;
    execute_valid_d = 1'b0;

    // Once halt is seen the fetch ID is frozen; no further IDs are consumed.
    if (halted_d) begin
      fetch_valid_d = 1'b0;
    end else if (!stall && fetch_valid) begin
      fetch_id_d = next_id(fetch_id);
    end

    if (stall) begin
      decode_valid_d = decode_valid & ~flush_id;
    end else begin
      decode_id_d     = fetch_id;
      decode_valid_d  = fetch_valid & ~flush_if;
      execute_valid_d = decode_valid & ~flush_id;
    end

    squash_inc = {1'b0, fetch_valid & flush_if & ~stall} + {1'b0, decode_valid & flush_id};
    any_valid  = fetch_valid | decode_valid | execute_valid | memory_valid | wb_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted        <= 1'b0;
      fetch_id      <= '0;
      fetch_valid   <= 1'b1;
      decode_id     <= '0;
      decode_valid  <= 1'b0;
      execute_id    <= '0;
      execute_valid <= 1'b0;
      memory_id     <= '0;
      memory_valid  <= 1'b0;
      wb_id         <= '0;
      wb_valid      <= 1'b0;
      retire_count  <= '0;
      squash_count  <= '0;
      stall_count   <= '0;
      drained       <= 1'b0;
    end else begin
      halted        <= halted_d;
      fetch_id      <= fetch_id_d;
      fetch_valid   <= fetch_valid_d;
      decode_id     <= decode_id_d;
      decode_valid  <= decode_valid_d;
      // EX always samples the ID-stage tag; a stall only clears its valid.
      execute_id    <= decode_id;
      execute_valid <= execute_valid_d;
      memory_id     <= execute_id;
      memory_valid  <= execute_valid;
      wb_id         <= memory_id;
      wb_valid      <= memory_valid;
      retire_count  <= sat_add(retire_count, {1'b0, wb_valid});
      stall_count   <= sat_add(stall_count, {1'b0, stall});
      squash_count  <= sat_add(squash_count, squash_inc);
      drained       <= halted & ~any_valid;
    end
  end

endmodule

// File: tb/tb_pipeline_tracker.sv
// Directed bench for pipeline_tracker: retire order is scoreboarded against an expected ID queue,
// stage/counter values are checked at hand-computed cycles.
module tb_pipeline_tracker;
  localparam int DEPTH = 72;
  localparam int ID_W  = $clog2(DEPTH);
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             flush_if;
  logic             flush_id;
  logic             halt;
  logic [ID_W-1:0]  fetch_id, decode_id, execute_id, memory_id, wb_id;
  logic             fetch_valid, decode_valid, execute_valid, memory_valid, wb_valid;
  logic [CNT_W-1:0] retire_count, squash_count, stall_count;
  logic             drained;

  logic [ID_W-1:0] exp_q[$];
  int total;
  int bad;
  int cyc;

  pipeline_tracker #(.DEPTH(DEPTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush_if(flush_if), .flush_id(flush_id), .halt(halt),
    .fetch_id(fetch_id), .fetch_valid(fetch_valid),
    .decode_id(decode_id), .decode_valid(decode_valid),
    .execute_id(execute_id), .execute_valid(execute_valid),
    .memory_id(memory_id), .memory_valid(memory_valid),
    .wb_id(wb_id), .wb_valid(wb_valid),
    .retire_count(retire_count), .squash_count(squash_count), .stall_count(stall_count),
    .drained(drained)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; stall = 1'b0; flush_if = 1'b0; flush_id = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    exp_q.delete();
  endtask

  task automatic push_ids(input int lo, input int hi);
    for (int k = lo; k < hi; k++) exp_q.push_back(ID_W'(k % DEPTH));
  endtask

  // One clock; afterwards the state of cycle 'cyc' is visible and retirements are scoreboarded.
  task automatic tick();
    logic [ID_W-1:0] e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (wb_valid) begin
      if (exp_q.size() == 0) chk("retire_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("retire_id", 32'(wb_id), 32'(e));
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;

    // free run
    reset_dut();
    chk("rst_fetch_valid", 32'(fetch_valid), 1);
    chk("rst_fetch_id", 32'(fetch_id), 0);
    chk("rst_decode_valid", 32'(decode_valid), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_drained", 32'(drained), 0);
    push_ids(0, 20);
    run_to(3);
    chk("free_wb_c3", 32'(wb_valid), 0);
    tick();
    chk("free_wb_c4", 32'(wb_valid), 1);
    run_to(10);
    chk("free_retire", retire_count, 6);

    // single stall at cycle 3
    reset_dut();
    push_ids(0, 20);
    run_to(3);
    chk("stall_dec_c3", 32'(decode_id), 2);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("stall_dec_c4", 32'(decode_id), 2);
    chk("stall_ex_bubble", 32'(execute_valid), 0);
    chk("stall_count", stall_count, 1);
    run_to(6);
    chk("stall_wb_bubble", 32'(wb_valid), 0);
    run_to(10);
    chk("stall_retire", retire_count, 5);

    // flush_if + flush_id at cycle 5
    reset_dut();
    push_ids(0, 4);
    push_ids(6, 20);
    run_to(5);
    flush_if = 1'b1; flush_id = 1'b1;
    tick();
    flush_if = 1'b0; flush_id = 1'b0;
    chk("flush_squash", squash_count, 2);
    chk("flush_dec_valid", 32'(decode_valid), 0);
    chk("flush_fetch_id", 32'(fetch_id), 6);
    run_to(8);
    chk("flush_wb_gap", 32'(wb_valid), 0);
    run_to(11);
    chk("flush_retire", retire_count, 5);

    // stall + flush_if: flush ignored
    reset_dut();
    push_ids(0, 20);
    run_to(3);
    stall = 1'b1; flush_if = 1'b1;
    tick();
    stall = 1'b0; flush_if = 1'b0;
    chk("sf_squash", squash_count, 0);
    chk("sf_fetch_id", 32'(fetch_id), 3);
    chk("sf_fetch_valid", 32'(fetch_valid), 1);
    run_to(10);
    chk("sf_squash_end", squash_count, 0);
    chk("sf_retire", retire_count, 5);

    // ID wrap past DEPTH
    reset_dut();
    push_ids(0, 100);
    run_to(71);
    chk("wrap_fetch_71", 32'(fetch_id), 71);
    tick();
    chk("wrap_fetch_0", 32'(fetch_id), 0);
    run_to(80);
    chk("wrap_retire", retire_count, 76);

    // halt at cycle 8, full drain
    reset_dut();
    push_ids(0, 9);
    run_to(8);
    chk("halt_fv_c8", 32'(fetch_valid), 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_fv_c9", 32'(fetch_valid), 0);
    chk("halt_dec_id", 32'(decode_id), 8);
    chk("halt_dec_valid", 32'(decode_valid), 1);
    run_to(12);
    chk("halt_wb_last", 32'(wb_valid), 1);
    chk("halt_drained_c12", 32'(drained), 0);
    run_to(14);
    chk("halt_drained_c14", 32'(drained), 1);
    chk("halt_retire", retire_count, 9);
    run_to(17);
    chk("halt_drained_sticky", 32'(drained), 1);
    chk("halt_fv_stays", 32'(fetch_valid), 0);

    // halt again, async reset mid-drain
    reset_dut();
    push_ids(0, 9);
    run_to(8);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    run_to(10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_retire", retire_count, 0);
    chk("arst_stall_count", stall_count, 0);
    chk("arst_mem_valid", 32'(memory_valid), 0);
    chk("arst_wb_valid", 32'(wb_valid), 0);
    chk("arst_fetch_valid", 32'(fetch_valid), 1);
    chk("arst_decode_id", 32'(decode_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    exp_q.delete();
    push_ids(0, 20);
    tick();
    chk("arst_first_dec_id", 32'(decode_id), 0);
    chk("arst_first_dec_valid", 32'(decode_valid), 1);
    run_to(12);
    chk("arst_unhalted", 32'(fetch_valid), 1);
    chk("arst_not_drained", 32'(drained), 0);
    chk("arst_retire_after", retire_count, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_tracker.md
# pipeline_tracker

Sequence-ID tracker for the 5-stage pipeline testbench. It assigns a wrapping sequence ID to every fetched instruction and carries an ID/valid pair through the IF, ID, EX, MEM and WB stages. Stall inserts a bubble and flushes squash instructions, mirroring the CPU's hazard behaviour. Its per-stage ID/valid outputs are the indices the downstream Verification_Unit uses to file stage messages and print retired instructions; it also provides retire, squash and stall statistics and a drain indication.

## Interface
- DEPTH, 72, size of the downstream message buffer; sequence IDs wrap modulo DEPTH
- ID_W, $clog2(DEPTH), sequence-ID width
- CNT_W, 32, statistics counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  load-use stall: PC and IF/ID hold, bubble into ID/EX
- flush_if  in  1  squash the instruction currently in IF (taken branch)
- flush_id  in  1  squash the instruction currently in ID
- halt  in  1  halt decoded; no new fetch IDs are issued from the next cycle onward
- fetch_id / fetch_valid  out  ID_W / 1  IF-stage ID and valid
- decode_id / decode_valid  out  ID_W / 1  ID-stage ID and valid
- execute_id / execute_valid  out  ID_W / 1  EX-stage ID and valid
- memory_id / memory_valid  out  ID_W / 1  MEM-stage ID and valid
- wb_id / wb_valid  out  ID_W / 1  WB-stage ID and valid (retire strobe)
- retire_count  out  CNT_W  instructions retired
- squash_count  out  CNT_W  valid instructions squashed by a flush
- stall_count  out  CNT_W  cycles with stall asserted
- drained  out  1  halt has been seen and all stage valids are 0

## Operation
- Reset (asynchronous, rst_n low):
  - all IDs 0
  - fetch_valid 1; decode/execute/memory/wb_valid 0
  - all counters 0; drained 0; internal halted flag 0
- ID increment: next = (id == DEPTH-1) ? 0 : id+1. An ID is consumed whenever fetch_valid advances, even if that instruction is later squashed.
- Priority per edge: stall over flush_if. flush_id always applies.
- stall = 1:
  - fetch_id/fetch_valid and decode_id/decode_valid hold
  - execute_valid <= 0 (bubble); execute_id <= decode_id
  - memory <= execute; wb <= memory
  - flush_if is ignored
- stall = 0:
  - decode_id <= fetch_id; decode_valid <= fetch_valid & ~flush_if
  - fetch_id advances if fetch_valid
  - execute_id <= decode_id; execute_valid <= decode_valid & ~flush_id
  - memory <= execute; wb <= memory
- flush_id with stall = 1: the EX bubble is inserted regardless; the ID instruction holds but is marked invalid (decode_valid <= 0).
- halt:
  - the halted flag sets on the edge where halt = 1 and is sticky until reset
  - fetch_valid <= 0 from that edge; fetch_id freezes
- Counters saturate at all-ones:
  - retire_count +1 per cycle with wb_valid = 1
  - stall_count +1 per cycle with stall = 1
  - squash_count +1 for each valid instruction removed: fetch_valid & flush_if & ~stall, and decode_valid & flush_id. Both can add on the same edge, for +2.
- drained = halted & ~(fetch_valid | decode_valid | execute_valid | memory_valid | wb_valid), registered.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Latency with no hazards: an ID in IF at cycle k is in ID at k+1, EX at k+2, MEM at k+3 and WB at k+4. Each stall cycle adds 1.
- Steady state: one new ID per cycle; at most 5 IDs in flight, always below DEPTH.
- Counter outputs reflect events up to and including the previous edge.
- drained rises one cycle after the last valid leaves WB.
- Reset asserted mid-operation clears all outputs immediately, without waiting for clk. The first edge after rst_n rises yields decode_id 0, decode_valid 1.

## Test plan
- Free run 10 cycles after reset -> wb_valid first high at cycle 4 with wb_id 0, then IDs 1,2,3…; retire_count 6.
- Single stall cycle at cycle 3 -> decode_id held for 2 cycles; execute_valid 0 for one cycle; WB sequence 0,1,bubble,2; stall_count 1.
- flush_if and flush_id together at cycle 5 -> the IF and ID IDs never reach WB; squash_count 2; retired IDs skip those two values.
- stall and flush_if together -> flush ignored; the held IF ID still retires; squash_count unchanged.
- Run past 72 fetches -> fetch_id goes 71→0; wb_id wraps identically; no gaps without flushes.
- halt at cycle 8, plus rst_n pulsed low mid-drain on a second run -> fetch_valid 0 from cycle 9; drained 1 five cycles after halt (last valid leaves WB) and stays high; the async reset zeros all counters and valids immediately.
